sram_axi_bridge: RTL
====================

Name:
sram_axi_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data SRAM-like ports, and is the only path from the core to the system bus.
- Converts the two request/addr_ok/data_ok slave channels (inst read-only, data read/write) into one single-beat AXI3 master.
- Allows at most one outstanding read and one outstanding write.
- Read ownership is arbitrated, with the data port taking priority over the inst port.

Parameters:
none (all address and data widths are fixed at 32).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
inst_req  in  1  inst read request
inst_addr  in  32  inst byte address
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst_rdata valid this cycle
inst_rdata  out  32  inst read data
data_req  in  1  data request
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  write byte strobes
data_addr  in  32  data byte address
data_wdata  in  32  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data read or write completed this cycle
data_rdata  out  32  data read data
arid  out  4  0 = inst, 1 = data
araddr  out  32  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  32  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data
wstrb  out  4  write strobes
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, on resetn.
- Reset state (resetn low at a clk edge):
  - both FSMs go to IDLE;
  - all valid, ready, addr_ok and data_ok outputs are 0;
  - address, data and rdata buffers are 0.
- Reset mid-operation abandons the transaction. Any R or B response arriving after reset is ignored.
- Read FSM, R_IDLE -> R_AR -> R_R -> R_IDLE:
  - R_IDLE grant:
    - data wins if data_req=1, data_wr=0 and no data operation is outstanding;
    - otherwise inst wins if inst_req=1.
  - The winner's addr_ok is combinational, high for that cycle only. Address, size and owner are latched on the same edge.
  - R_AR: arvalid=1. araddr, arid and arsize are held stable until arready.
  - R_R: rready=1. On rvalid, rdata is latched into the owner's rdata register.
  - The owner's data_ok pulses high for exactly one cycle, the cycle after the R handshake. The FSM returns to R_IDLE on that same edge.
  - Minimum latency: addr_ok in cycle 0, arvalid in cycle 1, rvalid in cycle 2 earliest, data_ok in cycle 3.
- Write FSM, W_IDLE -> W_AWW -> W_B -> W_IDLE:
  - W_IDLE: data_addr_ok=1 when data_req=1, data_wr=1 and no data operation is outstanding. awaddr, awsize, wdata and wstrb are latched.
  - W_AWW: awvalid and wvalid are both raised together. Each drops independently after its own handshake. The FSM leaves W_AWW once both handshakes are done.
  - W_B: bready=1. data_data_ok pulses for one cycle, the cycle after the bvalid handshake.
  - data_rdata keeps its old value on writes.
- Data port ordering: at most one data operation in flight. This is the RAW/WAR guard. data_addr_ok is held low until the previous data_data_ok.
- Inst reads proceed while a data write is outstanding.
- Size mapping:
  - data requests: arsize and awsize = {1'b0, data_size};
  - inst requests: arsize = 3'd2.
- Simultaneous events: inst_data_ok and data_data_ok may both be high in the same cycle (a read completing alongside a write).
- rresp and bresp are not ported. Errors are ignored.

Decomposition:
- The shared CPU package holds:
  - the AXI ID constants (INST_ID=0, DATA_ID=1, WRITE_ID=1);
  - the fixed AXI fields, driven by the top-level wrapper: len=0, burst=INCR 2'b01, lock/cache/prot=0, wlast=1;
  - the read and write FSM state encodings.
- No sub-module. The two FSMs live in one file.

Test Plan:
- Inst read, zero-wait slave:
  - stimulus: inst_req, addr 0x1c000000, arready=1, rvalid one cycle after the AR handshake with rdata 0x02800c0c;
  - response: addr_ok in cycle 0; arvalid in cycle 1 with arid=0, arsize=2; inst_data_ok in cycle 3 with rdata 0x02800c0c.
- Inst and data read requested in the same cycle, data addr 0x1c008000:
  - data is granted first, with arid=1;
  - inst_addr_ok rises only in R_IDLE after data_data_ok.
- Byte store, size 0, addr 0x1c008002, wstrb 0x4, wdata 0x00ab0000; awready delayed 3 cycles, wready immediate:
  - wvalid high for 1 cycle;
  - awvalid and awaddr stable for 3 cycles, with awsize=0;
  - data_data_ok one cycle after bvalid.
- Data read issued while a write waits in W_B:
  - data_addr_ok stays 0 until the write's data_data_ok;
  - a concurrent inst read completes meanwhile.
- arready held low for 5 cycles:
  - araddr, arid and arsize are unchanged across all 5 cycles;
  - no second addr_ok is issued.
- resetn low during R_R:
  - next cycle rready=0 and all data_ok outputs are 0;
  - a late rvalid produces no data_ok.

Source files
------------

// File: rtl/sram_axi_bridge_pkg.sv
// Shared CPU-side bus definitions: AXI IDs, fixed single-beat AXI3 fields
// and the state encodings of the bridge's read and write FSMs.
package sram_axi_bridge_pkg;

    localparam logic [3:0] INST_ID  = 4'd0;
    localparam logic [3:0] DATA_ID  = 4'd1;
    localparam logic [3:0] WRITE_ID = 4'd1;

    // Fixed AXI3 fields for single-beat transfers, tied off by the wrapper.
    localparam logic [3:0] AXI_LEN   = 4'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'd0;
    localparam logic [2:0] AXI_PROT  = 3'd0;
    localparam logic       AXI_WLAST = 1'b1;

    localparam logic [2:0] INST_SIZE = 3'd2;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AWW  = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge.sv
// Converts the core's inst (read-only) and data (read/write) SRAM-like ports
// into one single-beat AXI3 master with one outstanding read and one write.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   rd_state_q;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic [3:0]  ar_id_q;
    logic        ar_valid_q;
    logic        r_ready_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        inst_ok_q;
    logic        data_rd_ok_q;

    wr_state_e   wr_state_q;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        aw_valid_q;
    logic        w_valid_q;
    logic        b_ready_q;
    logic        data_wr_ok_q;

    logic        data_busy;
    logic        data_rd_grant;
    logic        inst_rd_grant;
    logic        data_wr_accept;
    logic        aw_done;
    logic        w_done;

    // Both FSMs return to idle on the edge that raises data_ok, so the data
    // port is free again in the same cycle its completion is reported.
    always_comb begin
        data_busy      = ((rd_state_q != R_IDLE) && (ar_id_q == DATA_ID)) ||
                         (wr_state_q != W_IDLE);
        data_rd_grant  = (rd_state_q == R_IDLE) && data_req && !data_wr && !data_busy;
        inst_rd_grant  = (rd_state_q == R_IDLE) && inst_req && !data_rd_grant;
        data_wr_accept = (wr_state_q == W_IDLE) && data_req && data_wr && !data_busy;
        aw_done        = !aw_valid_q || awready;
        w_done         = !w_valid_q || wready;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_state_q   <= R_IDLE;
            ar_addr_q    <= '0;
            ar_size_q    <= '0;
            ar_id_q      <= '0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_rd_ok_q <= 1'b0;
        end else begin
            inst_ok_q    <= 1'b0;
            data_rd_ok_q <= 1'b0;
            unique case (rd_state_q)
                R_IDLE: begin
                    if (data_rd_grant) begin
                        ar_addr_q  <= data_addr;
                        ar_size_q  <= axi_size(data_size);
                        ar_id_q    <= DATA_ID;
                        ar_valid_q <= 1'b1;
                        rd_state_q <= R_AR;
                    end else if (inst_rd_grant) begin
                        ar_addr_q  <= inst_addr;
                        ar_size_q  <= INST_SIZE;
                        ar_id_q    <= INST_ID;
                        ar_valid_q <= 1'b1;
                        rd_state_q <= R_AR;
                    end
                end
                R_AR: begin
                    if (arready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        rd_state_q <= R_R;
                    end
                end
                R_R: begin
                    if (rvalid) begin
                        r_ready_q <= 1'b0;
                        if (ar_id_q == DATA_ID) begin
                            data_rdata_q <= rdata;
                            data_rd_ok_q <= 1'b1;
                        end else begin
                            inst_rdata_q <= rdata;
                            inst_ok_q    <= 1'b1;
                        end
                        rd_state_q <= R_IDLE;
                    end
                end
                default: begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    rd_state_q <= R_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_state_q   <= W_IDLE;
            aw_addr_q    <= '0;
            aw_size_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            data_wr_ok_q <= 1'b0;
        end else begin
            data_wr_ok_q <= 1'b0;
            unique case (wr_state_q)
                W_IDLE: begin
                    if (data_wr_accept) begin
                        aw_addr_q  <= data_addr;
                        aw_size_q  <= axi_size(data_size);
                        w_data_q   <= data_wdata;
                        w_strb_q   <= data_wstrb;
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        wr_state_q <= W_AWW;
                    end
                end
                W_AWW: begin
                    // AW and W complete independently; leave once both are done.
                    if (aw_valid_q && awready) begin
                        aw_valid_q <= 1'b0;
                    end
                    if (w_valid_q && wready) begin
                        w_valid_q <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        b_ready_q  <= 1'b1;
                        wr_state_q <= W_B;
                    end
                end
                W_B: begin
                    if (bvalid) begin
                        b_ready_q    <= 1'b0;
                        data_wr_ok_q <= 1'b1;
                        wr_state_q   <= W_IDLE;
                    end
                end
                default: begin
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                    wr_state_q <= W_IDLE;
                end
            endcase
        end
    end

    assign inst_addr_ok = inst_rd_grant;
    assign inst_data_ok = inst_ok_q;
    assign inst_rdata   = inst_rdata_q;

    assign data_addr_ok = data_rd_grant || data_wr_accept;
    assign data_data_ok = data_rd_ok_q || data_wr_ok_q;
    assign data_rdata   = data_rdata_q;

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arsize  = ar_size_q;
    assign arvalid = ar_valid_q;
    assign rready  = r_ready_q;

    assign awaddr  = aw_addr_q;
    assign awsize  = aw_size_q;
    assign awvalid = aw_valid_q;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wvalid  = w_valid_q;
    assign bready  = b_ready_q;

endmodule
